tdp18k_preload_ctl: RTL and testbench
=====================================

Name: tdp18k_preload_ctl

Overview:
- Single-clock sequencer that drives the PL_* preload port of one TDP18K_FIFO tile, or of all tiles in broadcast mode.
- Bulk-loads a contiguous, wrapping range of 18-bit words from a valid/ready stream.
- Optionally reads the range back through PL_DATA_OUT and checks it with an additive checksum.
- Sits between the configuration/bootstrap fabric and the BRAM tiles; user-mode ports are untouched whenever PL_ENA_o is low.

Parameters:
- RAM_ID, 20'h00401, tile ID placed in PL_ADDR_o[31:12]: [31:22]=RAM_ID[19:10], [21:12]=RAM_ID[9:0].
- BROADCAST, 1'b0, 1 = drive PL_INIT_o high during a job so every tile accepts it.
- VERIFY, 1'b1, 1 = run the readback/checksum phase after writing.

Ports:
- CLK_i  in  1  single clock; also drives the tile's PL_CLK_i.
- RST_ni  in  1  asynchronous, active-low reset.
- START_i  in  1  job request; sampled only in IDLE.
- ABORT_i  in  1  synchronous job cancel.
- BASE_ADDR_i  in  10  first word address; captured on START.
- WORDS_i  in  11  word count; 0 means empty job; values >1024 are clamped to 1024.
- DIN_VALID_i  in  1  stream data valid.
- DIN_i  in  18  stream data.
- DIN_READY_o  out  1  stream ready.
- PL_INIT_o  out  1  to tile PL_INIT_i.
- PL_ENA_o  out  1  to tile PL_ENA_i.
- PL_WEN_o  out  1  to tile PL_WEN_i.
- PL_REN_o  out  1  to tile PL_REN_i.
- PL_ADDR_o  out  32  to tile PL_ADDR_i.
- PL_DATA_IN_o  out  18  to tile PL_DATA_IN_i.
- PL_DATA_OUT_i  in  18  from tile PL_DATA_OUT_o.
- BUSY_o  out  1  high when state is not IDLE.
- DONE_o  out  1  one-cycle completion pulse.
- ERR_o  out  1  sticky per job: checksum mismatch or abort.
- CHKSUM_o  out  18  write-phase checksum of the last job.

Behaviour:
- Reset values: state IDLE; all outputs 0; PL_ADDR_o[31:12]=RAM_ID, [11:0]=0. The address ID field is constant at all times.
- States: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - START_i=1 captures BASE_ADDR_i and the clamped WORDS_i into cnt.
  - Clears ERR_o, CHKSUM_o and the internal read sum.
  - Next state is WRITE, or FINISH if the count is 0.
  - START_i is ignored in every other state.
- WRITE:
  - PL_ENA_o=1 and DIN_READY_o=1.
  - PL_WEN_o = DIN_VALID_i (combinational); PL_DATA_IN_o = DIN_i (combinational).
  - PL_ADDR_o[9:0] = current word address.
  - On valid&ready: word is written at the clock edge; CHKSUM_o += DIN_i mod 2^18; address += 1 mod 1024; cnt -= 1.
  - DIN_VALID_i=0 stalls with PL_WEN_o=0 and the address held.
  - When the last word is accepted: go to READ if VERIFY, else FINISH.
- READ:
  - Address reloaded to base, cnt reloaded. PL_ENA_o=1, PL_WEN_o=0, PL_REN_o=1.
  - One address is issued per cycle, no stalls.
  - Read latency is exactly 1 cycle: PL_DATA_OUT_i in cycle n+1 belongs to the address issued in cycle n.
  - A delayed-valid flag adds PL_DATA_OUT_i to the read sum.
  - After the last address is issued, go to DRAIN.
- DRAIN: PL_ENA_o=1, PL_REN_o=0; captures the final read word; next state FINISH.
- FINISH:
  - PL_ENA_o=0, DONE_o=1 for exactly one cycle.
  - ERR_o |= (VERIFY and read sum != CHKSUM_o).
  - Next state IDLE.
- PL_INIT_o = BROADCAST & PL_ENA_o.
- PL_ENA_o drops in the same cycle FINISH is entered, so the tile returns to user mode on the following edge.
- Wrap-around: base 1020 with 8 words writes 1020..1023, then 0..3.
- WORDS_i=1024: every address is written exactly once.
- ABORT_i in WRITE, READ or DRAIN: no further PL_WEN/PL_REN asserted; go to FINISH; ERR_o=1, DONE_o pulses. ABORT_i in IDLE or FINISH is ignored.
- Asynchronous reset mid-job: all outputs go to reset values immediately. PL_ENA_o drops with no glitch on PL_WEN_o; partially written data remains in the tile.
- Width rules: the checksum and read sum are 18-bit with wrap; address is 10-bit with wrap; cnt is 11-bit.

Test Plan:
- Basic load: base=0, WORDS=4, data 1,2,3,4 with VALID always high -> PL_WEN_o high for 4 cycles at addr 0..3; READ 4 cycles; DONE_o pulses; CHKSUM_o=10; ERR_o=0; total 4+4+1+1 cycles after START.
- Stall: DIN_VALID_i toggles 1,0,1,0 over 6 words -> PL_WEN_o only on valid cycles; addresses strictly increment; DONE_o after the 6th accepted word plus the verify phase.
- Wrap and clamp: base=1020, WORDS=8, then base=0, WORDS=2047 -> first job addresses 1020..1023, 0..3; second job writes 1024 words exactly.
- Corruption: bench model flips bit 0 of the 3rd readback word -> ERR_o=1 at DONE_o; CHKSUM_o still equals the write sum.
- Edge commands: WORDS=0 -> DONE_o one cycle after START, no PL_ENA_o; ABORT_i on 2nd write -> only 1 word written, DONE_o=1, ERR_o=1; START_i while BUSY_o=1 -> ignored.
- Reset and broadcast: RST_ni low mid-READ -> all outputs 0 the same cycle. With BROADCAST=1 -> PL_INIT_o mirrors PL_ENA_o and PL_ADDR_o[31:12]=20'h00401.

Source files
------------

// File: rtl/tdp18k_preload_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tdp18k_preload_ctl
// Brief    : Bulk-preload sequencer for a TDP18K_FIFO tile PL_* port with
//            optional readback and additive-checksum verification.
// Revision : 1.0 - initial release
// ============================================================================
module tdp18k_preload_ctl #(
  parameter logic [19:0] RAM_ID    = 20'h00401,
  parameter bit          BROADCAST = 1'b0,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic        CLK_i,
  input  logic        RST_ni,
  input  logic        START_i,
  input  logic        ABORT_i,
  input  logic [9:0]  BASE_ADDR_i,
  input  logic [10:0] WORDS_i,
  input  logic        DIN_VALID_i,
  input  logic [17:0] DIN_i,
  output logic        DIN_READY_o,
  output logic        PL_INIT_o,
  output logic        PL_ENA_o,
  output logic        PL_WEN_o,
  output logic        PL_REN_o,
  output logic [31:0] PL_ADDR_o,
  output logic [17:0] PL_DATA_IN_o,
  input  logic [17:0] PL_DATA_OUT_i,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic        ERR_o,
  output logic [17:0] CHKSUM_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [10:0] c_MAX_WORDS = 11'd1024;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_base;
  logic [9:0]  r_addr;
  logic [10:0] r_len;
  logic [10:0] r_cnt;
  logic [17:0] r_chksum;
  logic [17:0] r_rsum;
  logic        r_rd_vld;
  logic        r_err;
  logic [10:0] w_words;
  logic        w_accept;
  logic        w_mismatch;

  assign w_words    = (WORDS_i > c_MAX_WORDS) ? c_MAX_WORDS : WORDS_i;
  assign w_mismatch = VERIFY && (r_rsum != r_chksum);

  always_comb begin
    w_next      = r_state;
    DIN_READY_o = 1'b0;
    PL_ENA_o    = 1'b0;
    PL_WEN_o    = 1'b0;
    PL_REN_o    = 1'b0;
    DONE_o      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START_i) w_next = (w_words == 11'd0) ? S_FINISH : S_WRITE;
      end
      S_WRITE: begin
        PL_ENA_o = 1'b1;
        if (ABORT_i) begin
          w_next = S_FINISH;
        end else begin
          DIN_READY_o = 1'b1;
          PL_WEN_o    = DIN_VALID_i;
          w_accept    = DIN_VALID_i;
          if (DIN_VALID_i && r_cnt == 11'd1) w_next = VERIFY ? S_READ : S_FINISH;
        end
      end
      S_READ: begin
        PL_ENA_o = 1'b1;
        if (ABORT_i) begin
          w_next = S_FINISH;
        end else begin
          PL_REN_o = 1'b1;
          if (r_cnt == 11'd1) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        PL_ENA_o = 1'b1;
        w_next   = S_FINISH;
      end
      S_FINISH: begin
        DONE_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign BUSY_o       = (r_state != S_IDLE);
  assign PL_INIT_o    = BROADCAST & PL_ENA_o;
  // The tile ID field never changes; only the word address follows the job.
  assign PL_ADDR_o    = {RAM_ID, 2'b00, (PL_ENA_o ? r_addr : 10'd0)};
  assign PL_DATA_IN_o = (r_state == S_WRITE) ? DIN_i : 18'd0;
  assign ERR_o        = r_err | ((r_state == S_FINISH) & w_mismatch);
  assign CHKSUM_o     = r_chksum;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_state  <= S_IDLE;
      r_base   <= 10'd0;
      r_addr   <= 10'd0;
      r_len    <= 11'd0;
      r_cnt    <= 11'd0;
      r_chksum <= 18'd0;
      r_rsum   <= 18'd0;
      r_rd_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rd_vld <= PL_REN_o;
      // Data returned this cycle belongs to the address issued last cycle.
      if (r_rd_vld) r_rsum <= r_rsum + PL_DATA_OUT_i;
      case (r_state)
        S_IDLE: begin
          if (START_i) begin
            r_base   <= BASE_ADDR_i;
            r_addr   <= BASE_ADDR_i;
            r_len    <= w_words;
            r_cnt    <= w_words;
            r_chksum <= 18'd0;
            r_rsum   <= 18'd0;
            r_err    <= 1'b0;
          end
        end
        S_WRITE: begin
          if (ABORT_i) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_chksum <= r_chksum + DIN_i;
            if (r_cnt == 11'd1) begin
              r_addr <= r_base;
              r_cnt  <= r_len;
            end else begin
              r_addr <= r_addr + 10'd1;
              r_cnt  <= r_cnt - 11'd1;
            end
          end
        end
        S_READ: begin
          if (ABORT_i) begin
            r_err <= 1'b1;
          end else begin
            r_addr <= r_addr + 10'd1;
            r_cnt  <= r_cnt - 11'd1;
          end
        end
        S_DRAIN: begin
          if (ABORT_i) r_err <= 1'b1;
        end
        S_FINISH: begin
          r_err <= r_err | w_mismatch;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdp18k_preload_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdp18k_preload_ctl
// Brief    : Directed self-checking bench with a behavioural 1-cycle BRAM tile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdp18k_preload_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, din_valid, din_ready;
  logic [9:0]  base_addr;
  logic [10:0] words;
  logic [17:0] din, pl_din, tile_dout, chksum;
  logic        pl_init, pl_ena, pl_wen, pl_ren, busy, done, err;
  logic [31:0] pl_addr;

  logic        b_start, b_valid, b_ready, b_init, b_ena, b_wen, b_ren, b_busy, b_done, b_err;
  logic [10:0] b_words;
  logic [17:0] b_din, b_pl_din, b_chksum;
  logic [17:0] b_dout = 18'd0;
  logic [31:0] b_addr;

  tdp18k_preload_ctl dut (
    .CLK_i(clk), .RST_ni(rst_n), .START_i(start), .ABORT_i(abort),
    .BASE_ADDR_i(base_addr), .WORDS_i(words), .DIN_VALID_i(din_valid), .DIN_i(din),
    .DIN_READY_o(din_ready), .PL_INIT_o(pl_init), .PL_ENA_o(pl_ena), .PL_WEN_o(pl_wen),
    .PL_REN_o(pl_ren), .PL_ADDR_o(pl_addr), .PL_DATA_IN_o(pl_din), .PL_DATA_OUT_i(tile_dout),
    .BUSY_o(busy), .DONE_o(done), .ERR_o(err), .CHKSUM_o(chksum)
  );

  tdp18k_preload_ctl #(.BROADCAST(1'b1), .VERIFY(1'b0)) dut_b (
    .CLK_i(clk), .RST_ni(rst_n), .START_i(b_start), .ABORT_i(1'b0),
    .BASE_ADDR_i(10'd7), .WORDS_i(b_words), .DIN_VALID_i(b_valid), .DIN_i(b_din),
    .DIN_READY_o(b_ready), .PL_INIT_o(b_init), .PL_ENA_o(b_ena), .PL_WEN_o(b_wen),
    .PL_REN_o(b_ren), .PL_ADDR_o(b_addr), .PL_DATA_IN_o(b_pl_din), .PL_DATA_OUT_i(b_dout),
    .BUSY_o(b_busy), .DONE_o(b_done), .ERR_o(b_err), .CHKSUM_o(b_chksum)
  );

  // Tile model: synchronous write, registered read, optional single-bit corruption.
  logic [17:0] mem [0:1023];
  logic        corrupt_en;
  logic [9:0]  corrupt_addr;
  always @(posedge clk) begin
    if (pl_ena && pl_wen) mem[pl_addr[9:0]] <= pl_din;
    if (pl_ena && pl_ren)
      tile_dout <= mem[pl_addr[9:0]] ^ {17'd0, (corrupt_en && pl_addr[9:0] == corrupt_addr)};
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] src [0:1023];
  int          wr_addr [$];
  logic [17:0] wr_data [$];
  int          n_ren, done_cyc, bad_wen, ena_seen, init_seen;
  logic        err_done;
  logic [17:0] chk_done;

  task automatic drive_job(input int b, input int w, input int vmode, input int abort_cyc,
                           input int restart_cyc);
    int k;
    wr_addr.delete(); wr_data.delete();
    n_ren = 0; done_cyc = -1; bad_wen = 0; ena_seen = 0; init_seen = 0;
    err_done = 1'b0; chk_done = 18'd0;
    @(negedge clk);
    start = 1'b1; base_addr = 10'(b); words = 11'(w); din_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      din_valid = (vmode == 0) || (cyc % 2 == 1);
      din       = src[k & 1023];
      abort     = (cyc == abort_cyc);
      start     = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin base_addr = 10'd500; words = 11'd9; end
      #1;
      if (pl_wen) begin
        wr_addr.push_back(int'(pl_addr[9:0])); wr_data.push_back(pl_din);
        if (!din_valid) bad_wen++;
      end
      if (din_ready && din_valid) k++;
      if (pl_ren) n_ren++;
      if (pl_ena) ena_seen++;
      if (pl_init) init_seen++;
      if (done) begin done_cyc = cyc; err_done = err; chk_done = chksum; break; end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 18'd0;
    base_addr = 10'd0; words = 11'd0; corrupt_en = 1'b0; corrupt_addr = 10'd0;
    b_start = 1'b0; b_valid = 1'b0; b_din = 18'd0; b_words = 11'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pl_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got=%0h exp=0", pl_ena); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, done, err); end
    checks++; if (chksum !== 18'd0) begin errors++; $display("FAIL reset_chksum got=%0h exp=0", chksum); end
    checks++; if (pl_addr !== {20'h00401, 12'h000}) begin errors++; $display("FAIL reset_addr got=%0h exp=00401000", pl_addr); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0h exp=0", din_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) src[i] = 18'(i + 1);
    drive_job(0, 4, 0, -1, -1);
    checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL basic_nwr got=%0d exp=4", wr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wr_addr.size() || wr_addr[i] != i || wr_data[i] !== 18'(i + 1)) begin
        errors++; $display("FAIL basic_wr%0d got addr=%0d data=%0h exp addr=%0d data=%0h", i,
                           (i < wr_addr.size()) ? wr_addr[i] : -1, (i < wr_data.size()) ? wr_data[i] : 18'h0, i, i + 1);
      end
    end
    checks++; if (n_ren != 4) begin errors++; $display("FAIL basic_nren got=%0d exp=4", n_ren); end
    checks++; if (done_cyc != 10) begin errors++; $display("FAIL basic_done_cyc got=%0d exp=10", done_cyc); end
    checks++; if (chk_done !== 18'd10) begin errors++; $display("FAIL basic_chksum got=%0d exp=10", chk_done); end
    checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL basic_err got=%0h exp=0", err_done); end
    checks++; if (init_seen != 0) begin errors++; $display("FAIL basic_init got=%0d exp=0", init_seen); end
    checks++; if (mem[2] !== 18'd3) begin errors++; $display("FAIL basic_mem2 got=%0h exp=3", mem[2]); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after got done=%0h busy=%0h exp 0 0", done, busy); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 6; i++) src[i] = 18'(10 * (i + 1));
    drive_job(5, 6, 1, -1, -1);
    checks++; if (wr_addr.size() != 6 || bad_wen != 0) begin errors++; $display("FAIL stall_nwr got=%0d bad=%0d exp=6 bad=0", wr_addr.size(), bad_wen); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= wr_addr.size() || wr_addr[i] != 5 + i) begin errors++; $display("FAIL stall_addr%0d got=%0d exp=%0d", i, (i < wr_addr.size()) ? wr_addr[i] : -1, 5 + i); end
    end
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL stall_done_cyc got=%0d exp=19", done_cyc); end
    checks++; if (chk_done !== 18'd210 || err_done !== 1'b0) begin errors++; $display("FAIL stall_result got chk=%0d err=%0h exp chk=210 err=0", chk_done, err_done); end
  endtask

  task automatic test_wrap_clamp();
    int dup, missing;
    bit seen [0:1023];
    for (int i = 0; i < 8; i++) src[i] = 18'(100 + i);
    drive_job(1020, 8, 0, -1, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= wr_addr.size() || wr_addr[i] != (1020 + i) % 1024) begin errors++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, (i < wr_addr.size()) ? wr_addr[i] : -1, (1020 + i) % 1024); end
    end
    checks++; if (done_cyc != 18 || chk_done !== 18'd828 || err_done !== 1'b0) begin errors++; $display("FAIL wrap_result got cyc=%0d chk=%0d err=%0h exp 18 828 0", done_cyc, chk_done, err_done); end
    for (int i = 0; i < 1024; i++) begin src[i] = 18'(i); seen[i] = 1'b0; end
    drive_job(0, 2047, 0, -1, -1);
    dup = 0; missing = 0;
    foreach (wr_addr[j]) begin if (seen[wr_addr[j]]) dup++; seen[wr_addr[j]] = 1'b1; end
    for (int i = 0; i < 1024; i++) if (!seen[i]) missing++;
    checks++; if (wr_addr.size() != 1024 || dup != 0 || missing != 0) begin errors++; $display("FAIL clamp_cover got n=%0d dup=%0d miss=%0d exp 1024 0 0", wr_addr.size(), dup, missing); end
    checks++; if (done_cyc != 2050) begin errors++; $display("FAIL clamp_done_cyc got=%0d exp=2050", done_cyc); end
    checks++; if (chk_done !== 18'd261632 || err_done !== 1'b0) begin errors++; $display("FAIL clamp_result got chk=%0d err=%0h exp 261632 0", chk_done, err_done); end
  endtask

  task automatic test_corrupt();
    for (int i = 0; i < 4; i++) src[i] = 18'(i + 1);
    corrupt_en = 1'b1; corrupt_addr = 10'd2;
    drive_job(0, 4, 0, -1, -1);
    corrupt_en = 1'b0;
    checks++; if (done_cyc != 10 || err_done !== 1'b1) begin errors++; $display("FAIL corrupt_err got cyc=%0d err=%0h exp 10 1", done_cyc, err_done); end
    checks++; if (chk_done !== 18'd10) begin errors++; $display("FAIL corrupt_chksum got=%0d exp=10", chk_done); end
    @(negedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL corrupt_sticky got=%0h exp=1", err); end
  endtask

  task automatic test_edges();
    drive_job(3, 0, 0, -1, -1);
    checks++; if (done_cyc != 1 || ena_seen != 0) begin errors++; $display("FAIL zero_job got cyc=%0d ena=%0d exp 1 0", done_cyc, ena_seen); end
    checks++; if (chk_done !== 18'd0 || err_done !== 1'b0) begin errors++; $display("FAIL zero_clear got chk=%0d err=%0h exp 0 0", chk_done, err_done); end
    src[0] = 18'd50; src[1] = 18'd51;
    drive_job(0, 4, 0, 2, -1);
    checks++; if (wr_addr.size() != 1 || n_ren != 0) begin errors++; $display("FAIL abort_wr_count got wr=%0d ren=%0d exp 1 0", wr_addr.size(), n_ren); end
    checks++; if (done_cyc != 3 || err_done !== 1'b1 || chk_done !== 18'd50) begin errors++; $display("FAIL abort_wr_result got cyc=%0d err=%0h chk=%0d exp 3 1 50", done_cyc, err_done, chk_done); end
    for (int i = 0; i < 4; i++) src[i] = 18'(i + 1);
    drive_job(0, 4, 0, 6, -1);
    checks++; if (n_ren != 1 || done_cyc != 7 || err_done !== 1'b1) begin errors++; $display("FAIL abort_rd got ren=%0d cyc=%0d err=%0h exp 1 7 1", n_ren, done_cyc, err_done); end
    drive_job(0, 4, 0, -1, 2);
    checks++; if (wr_addr.size() != 4 || wr_addr[3] != 3 || done_cyc != 10) begin errors++; $display("FAIL start_busy got wr=%0d cyc=%0d exp 4 10", wr_addr.size(), done_cyc); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_busy_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) src[i] = 18'(i + 1);
    @(negedge clk); start = 1'b1; base_addr = 10'd0; words = 11'd4; din_valid = 1'b1; din = 18'd9;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (pl_ren !== 1'b1) begin errors++; $display("FAIL rstmid_pre got ren=%0h exp=1", pl_ren); end
    rst_n = 1'b0; #1;
    checks++; if (pl_ena !== 1'b0 || pl_ren !== 1'b0 || pl_wen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got ena=%0h ren=%0h wen=%0h busy=%0h exp 0", pl_ena, pl_ren, pl_wen, busy); end
    checks++; if (chksum !== 18'd0 || pl_addr !== {20'h00401, 12'h000}) begin errors++; $display("FAIL rstmid_regs got chk=%0h addr=%0h exp 0 00401000", chksum, pl_addr); end
    din_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_broadcast();
    @(negedge clk); b_start = 1'b1; b_words = 11'd2; b_valid = 1'b1; b_din = 18'd7;
    @(negedge clk); b_start = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      #1;
      checks++;
      if (b_ena !== (cyc < 3) || b_init !== (cyc < 3) || b_done !== (cyc == 3) || b_addr[31:12] !== 20'h00401) begin
        errors++; $display("FAIL bcast_c%0d got ena=%0h init=%0h done=%0h id=%0h exp ena=init=%0d done=%0d id=00401",
                           cyc, b_ena, b_init, b_done, b_addr[31:12], cyc < 3, cyc == 3);
      end
      if (cyc == 3) begin
        checks++; if (b_chksum !== 18'd14 || b_err !== 1'b0) begin errors++; $display("FAIL bcast_result got chk=%0d err=%0h exp 14 0", b_chksum, b_err); end
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap_clamp();
    test_corrupt();
    test_edges();
    test_reset_mid();
    test_broadcast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
